// File: rtl/tff_timer_ctrl.sv
// tff_timer_ctrl
//   Sequencing controller for a synchronous T-FF up-counter. The controller clears
//   the counter and enables it until cnt_q reaches the terminal count (TC), then it
//   pulses done. It runs either one-shot or periodic, and it supports pause and stop.
//
//   Optional feature macro: TIMER_PRESCALE_EN. When this macro is defined, an
//   internal prescaler advances the counter only once every PRESCALE counting
//   cycles. When it is undefined, PRESCALE only sets the range check below.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     start request pulse, honoured only in IDLE
//   stop      abort, highest priority in every state
//   pause     level input; freezes counting while a run is active
//   periodic  auto-restart after done, sampled in DONE
//   tc_we     load tc_din into the TC register, honoured only in IDLE
//   tc_din    terminal count to load
//   cnt_q     counter value fed back from the counter
//   cnt_en    counter enable
//   cnt_clr   counter synchronous clear
//   busy      high whenever the state is not IDLE
//   done      one-cycle pulse when the terminal count is reached
//   tc_out    current TC register
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; TC register writable
// CLEAR | one cycle of cnt_clr, so the counter reads 0 in RUN
// RUN   | counting toward TC
// HOLD  | paused; counter and prescaler frozen
// DONE  | one-cycle done pulse, then restart or return to IDLE

module tff_timer_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic             tc_we,
    input  logic [WIDTH-1:0] tc_din,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] tc_out
);

    if (PRESCALE < 1) begin : g_prescale_check
        $error("tff_timer_ctrl: PRESCALE must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             at_tc;
    logic             counting;
    logic             cnt_step;

    assign at_tc = (cnt_q >= tc_q);

    // A HOLD cycle that sees pause released counts like a RUN cycle. This makes
    // each paused cycle cost exactly one cycle of run time.
    assign counting = ((state_q == S_RUN) || (state_q == S_HOLD))
                      && !pause && !stop && !at_tc;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          pre_wrap;

    assign pre_wrap = (pre_q == PRE_LAST);
    assign cnt_step = counting && pre_wrap;

    always_comb begin
        pre_d = pre_q;
        if (state_q == S_CLEAR) begin
            pre_d = '0;
        end else if (counting) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
        end
    end
`else
    assign cnt_step = counting;
`endif

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        case (state_q)
            S_IDLE: begin
                if (tc_we) begin
                    tc_d = tc_din;
                end
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_RUN;
            S_RUN: begin
                if (at_tc) begin
                    state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = periodic ? S_CLEAR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tc_q    <= '1;
`ifdef TIMER_PRESCALE_EN
            pre_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
`ifdef TIMER_PRESCALE_EN
            pre_q   <= pre_d;
`endif
        end
    end

    // Outputs are decoded directly from the state. A stop suppresses both the
    // clear and the done pulse, so the counter keeps its value on an abort.
    assign cnt_en  = cnt_step;
    assign cnt_clr = (state_q == S_CLEAR) && !stop;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE) && !stop;
    assign tc_out  = tc_q;

endmodule
